// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release pulses, sampled on divider taps.
// Optional auto-repeat on held buttons: define BTN_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int N_BTN        = 4,
    parameter int TAP          = 17,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic             tap_prev;
    logic             tick;
    logic [3:0]       cnt [N_BTN];
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] rpt;
    logic             unused_div;

    assign unused_div = ^clkdiv;
    assign tick       = clkdiv[TAP] & ~tap_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            tap_prev <= 1'b0;
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            tap_prev <= clkdiv[TAP];
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < N_BTN; i++) begin
            accept[i] = tick && (sync2[i] != btn_level[i])
                        && (cnt[i] == CNT_LAST);
        end
    end

    // Any agreeing sample restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]       <= '0;
                    btn_level[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [7:0] HOLD_LAST   = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] HOLD_RELOAD = 8'(REPEAT_DELAY - REPEAT_TICKS);

    logic [7:0] hold [N_BTN];

    // A tick that accepts a release never repeats.
    always_comb begin
        rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt[i] = tick && btn_level[i] && !accept[i]
                     && (hold[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_BTN; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i] || accept[i]) begin
                    hold[i] <= '0;
                end else if (tick) begin
                    if (rpt[i]) hold[i] <= HOLD_RELOAD;
                    else        hold[i] <= hold[i] + 8'd1;
                end
            end
        end
    end
`else
    assign rpt = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= (accept & sync2) | rpt;
            btn_release <= accept & ~sync2;
        end
    end

endmodule
